// File: rtl/mode1_max_stream_if.sv
// Handshake and data bundle for the streaming max-reduction stage.
// The master drives the vector beats and the slave returns the reduced maximum.
interface mode1_max_stream_if #(
    parameter int DATAWIDTH = 16,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic [CNT_W-1:0]     length;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] inp0;
    logic [DATAWIDTH-1:0] inp1;
    logic [DATAWIDTH-1:0] inp2;
    logic [DATAWIDTH-1:0] inp3;
    logic [DATAWIDTH-1:0] max_outp;
    logic                 max_valid;
    logic                 done;
    logic                 busy;

    modport master (
        output start, length, in_valid, inp0, inp1, inp2, inp3,
        input  in_ready, max_outp, max_valid, done, busy
    );

    modport slave (
        input  start, length, in_valid, inp0, inp1, inp2, inp3,
        output in_ready, max_outp, max_valid, done, busy
    );
endinterface

// File: rtl/mode1_max_stream.sv
// Streaming max reduction over 4-lane fp16 beats using integer ordering keys.
// Stage 1 reduces a beat to one element, stage 2 folds it into the running max.
module mode1_max_stream #(
    parameter int DATAWIDTH = 16,
    parameter int CNT_W     = 8
) (
    input logic               clk,
    input logic               reset,
    mode1_max_stream_if.slave bus
);
    localparam logic [DATAWIDTH-1:0] SIGN_BIT = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [DATAWIDTH-1:0] NEG_INF  = 16'hFC00;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 zero_start;
    logic                 run_start;
    logic [CNT_W-1:0]     beats_left;
    logic                 first;
    logic                 s1_v;
    logic [DATAWIDTH-1:0] s1_data;
    logic [DATAWIDTH-1:0] max_q;
    logic                 max_valid_q;
    logic                 done_q;
    logic [DATAWIDTH-1:0] m01;
    logic [DATAWIDTH-1:0] m23;
    logic [DATAWIDTH-1:0] beat_max;

    // Map fp16 bit patterns onto unsigned keys that follow IEEE total order.
    function automatic logic [DATAWIDTH-1:0] key(input logic [DATAWIDTH-1:0] x);
        return x[DATAWIDTH-1] ? ~x : (x ^ SIGN_BIT);
    endfunction

    // Lane tree: a later lane only wins on a strictly larger key.
    always_comb begin
        m01      = (key(bus.inp1) > key(bus.inp0)) ? bus.inp1 : bus.inp0;
        m23      = (key(bus.inp3) > key(bus.inp2)) ? bus.inp3 : bus.inp2;
        beat_max = (key(m23) > key(m01)) ? m23 : m01;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        zero_start = 1'b0;
        run_start  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) begin
                        zero_start = 1'b1;
                    end else begin
                        run_start = 1'b1;
                        state_nx  = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (beats_left == CNT_W'(1)) state_nx = FLUSH;
                end
            end
            FLUSH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: beat register, running max fold and completion flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beats_left  <= '0;
            first       <= 1'b0;
            s1_v        <= 1'b0;
            s1_data     <= '0;
            max_q       <= '0;
            max_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= zero_start || (state == FLUSH);
            s1_v   <= accept;
            if (accept) begin
                s1_data    <= beat_max;
                beats_left <= beats_left - CNT_W'(1);
            end
            if (s1_v) begin
                if (first) begin
                    max_q <= s1_data;
                    first <= 1'b0;
                end else if (key(s1_data) > key(max_q)) begin
                    max_q <= s1_data;
                end
            end
            if (state == FLUSH) max_valid_q <= 1'b1;
            if (zero_start) begin
                max_q       <= NEG_INF;
                max_valid_q <= 1'b1;
            end
            if (run_start) begin
                beats_left  <= bus.length;
                first       <= 1'b1;
                max_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.max_outp  = max_q;
    assign bus.max_valid = max_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state != IDLE) || done_q;
endmodule

// File: tb/tb_mode1_max_stream.sv
// Self-checking bench for mode1_max_stream: vector table, scoreboard queue,
// and hand-written sequences for zero length and reset mid-run.
module tb_mode1_max_stream;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] sb[$];

    mode1_max_stream_if #(.DATAWIDTH(16), .CNT_W(8)) bus ();

    mode1_max_stream #(.DATAWIDTH(16), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                     len;
        logic [3:0][3:0][15:0]  b;
        logic [15:0]            vpat;
        logic [15:0]            exp;
        bit                     xstart;
        string                  name;
    } vec_t;

    vec_t tbl[8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // a strictly above b in IEEE total order (sign/magnitude reasoning)
    function automatic bit gt(input logic [15:0] a, input logic [15:0] b);
        if (a[15] != b[15]) return b[15];
        if (!a[15]) return a > b;
        return a < b;
    endfunction

    function automatic logic [15:0] model_max(input int len,
                                              input logic [3:0][3:0][15:0] b);
        logic [15:0] m;
        m = b[0][0];
        for (int i = 0; i < len; i++)
            for (int l = 0; l < 4; l++)
                if (gt(b[i][l], m)) m = b[i][l];
        return m;
    endfunction

    task automatic run_vec(input vec_t v);
        int acc;
        int cyc;
        int lat;
        bit vb;
        logic [15:0] exp_q;
        bus.start  = 1'b1;
        bus.length = 8'(v.len);
        sb.push_back(model_max(v.len, v.b));
        tick;
        bus.start  = 1'b0;
        bus.length = 8'd77;
        chk({v.name, " busy_on"}, 32'(bus.busy), 32'd1);
        chk({v.name, " mv_clr"}, 32'(bus.max_valid), 32'd0);
        acc = 0;
        cyc = 0;
        while (acc < v.len && cyc < 200) begin
            vb = (cyc < 16) ? v.vpat[cyc] : 1'b1;
            chk({v.name, " rdy_hold"}, 32'(bus.in_ready), 32'd1);
            bus.in_valid = vb;
            bus.inp0 = vb ? v.b[acc][0] : 16'hFFFF;
            bus.inp1 = vb ? v.b[acc][1] : 16'hFFFF;
            bus.inp2 = vb ? v.b[acc][2] : 16'hFFFF;
            bus.inp3 = vb ? v.b[acc][3] : 16'hFFFF;
            if (v.xstart && cyc == 1) begin
                bus.start  = 1'b1;
                bus.length = 8'd0;
            end else begin
                bus.start = 1'b0;
            end
            tick;
            if (vb) acc++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.inp0 = 16'h7BFF;
        bus.inp1 = 16'h7BFF;
        bus.inp2 = 16'h7BFF;
        bus.inp3 = 16'h7BFF;
        chk({v.name, " beats_taken"}, 32'(acc), 32'(v.len));
        chk({v.name, " rdy_off"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.done && lat < 10) begin
            tick;
            lat++;
        end
        chk({v.name, " done_latency"}, 32'(lat), 32'd1);
        exp_q = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        chk({v.name, " max_sb"}, 32'(bus.max_outp), 32'(exp_q));
        chk({v.name, " max_tbl"}, 32'(bus.max_outp), 32'(v.exp));
        chk({v.name, " mv_set"}, 32'(bus.max_valid), 32'd1);
        chk({v.name, " busy_done"}, 32'(bus.busy), 32'd1);
        tick;
        chk({v.name, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({v.name, " mv_hold"}, 32'(bus.max_valid), 32'd1);
        chk({v.name, " max_hold"}, 32'(bus.max_outp), 32'(v.exp));
        chk({v.name, " busy_off"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.length   = 8'd0;
        bus.in_valid = 1'b0;
        bus.inp0 = '0;
        bus.inp1 = '0;
        bus.inp2 = '0;
        bus.inp3 = '0;

        for (int i = 0; i < 8; i++) begin
            tbl[i].b      = '0;
            tbl[i].vpat   = 16'hFFFF;
            tbl[i].xstart = 1'b0;
        end
        tbl[0].name = "single";
        tbl[0].len  = 1;
        tbl[0].b[0] = beat(16'h3C00, 16'h4000, 16'hBC00, 16'h3800);
        tbl[0].exp  = 16'h4000;
        tbl[1].name = "all_neg";
        tbl[1].len  = 2;
        tbl[1].b[0] = beat(16'hBC00, 16'hC000, 16'hC400, 16'hBE00);
        tbl[1].b[1] = beat(16'hC200, 16'hBD00, 16'hC000, 16'hC800);
        tbl[1].exp  = 16'hBC00;
        tbl[2].name = "bubbles";
        tbl[2].len  = 3;
        tbl[2].vpat = 16'b1111_1111_1110_1001;
        tbl[2].b[0] = beat(16'h3C00, 16'h3800, 16'h0000, 16'hBC00);
        tbl[2].b[1] = beat(16'h4000, 16'h3E00, 16'h8000, 16'hC000);
        tbl[2].b[2] = beat(16'h3C00, 16'h3A00, 16'h4200, 16'h4100);
        tbl[2].exp  = 16'h4200;
        tbl[3].name   = "xstart";
        tbl[3].len    = 4;
        tbl[3].xstart = 1'b1;
        tbl[3].b[0] = beat(16'h1000, 16'h2000, 16'h3000, 16'h0400);
        tbl[3].b[1] = beat(16'h7C00, 16'h4000, 16'h0000, 16'h8000);
        tbl[3].b[2] = beat(16'hFC00, 16'h5000, 16'h1234, 16'h0001);
        tbl[3].b[3] = beat(16'h3000, 16'h3000, 16'h3000, 16'h3000);
        tbl[3].exp  = 16'h7C00;
        tbl[4].name = "szero";
        tbl[4].len  = 1;
        tbl[4].b[0] = beat(16'h8000, 16'h0000, 16'h8000, 16'h0000);
        tbl[4].exp  = 16'h0000;
        tbl[5].name = "ties";
        tbl[5].len  = 1;
        tbl[5].b[0] = beat(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        tbl[5].exp  = 16'h3C00;
        tbl[6].name = "nan";
        tbl[6].len  = 1;
        tbl[6].b[0] = beat(16'h7E00, 16'h7C00, 16'hFE00, 16'h0000);
        tbl[6].exp  = 16'h7E00;
        tbl[7].name = "late_max";
        tbl[7].len  = 3;
        tbl[7].b[0] = beat(16'hC000, 16'hC100, 16'hC200, 16'hC300);
        tbl[7].b[1] = beat(16'hBC00, 16'hB800, 16'hC400, 16'hFC00);
        tbl[7].b[2] = beat(16'h8000, 16'h8001, 16'hA000, 16'h8400);
        tbl[7].exp  = 16'h8000;

        #12;
        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst max_valid", 32'(bus.max_valid), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst max_outp", 32'(bus.max_outp), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // zero-length request completes on the next edge with -inf
        bus.start  = 1'b1;
        bus.length = 8'd0;
        tick;
        bus.start = 1'b0;
        chk("zero done", 32'(bus.done), 32'd1);
        chk("zero max_valid", 32'(bus.max_valid), 32'd1);
        chk("zero max_outp", 32'(bus.max_outp), 32'hFC00);
        chk("zero in_ready", 32'(bus.in_ready), 32'd0);
        tick;
        chk("zero done_pulse", 32'(bus.done), 32'd0);
        chk("zero mv_hold", 32'(bus.max_valid), 32'd1);

        // reset after one of three beats
        bus.start  = 1'b1;
        bus.length = 8'd3;
        tick;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.inp0 = 16'h5000;
        bus.inp1 = 16'h0;
        bus.inp2 = 16'h0;
        bus.inp3 = 16'h0;
        tick;
        bus.in_valid = 1'b0;
        chk("mid in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst done", 32'(bus.done), 32'd0);
        chk("mrst max_valid", 32'(bus.max_valid), 32'd0);
        chk("mrst busy", 32'(bus.busy), 32'd0);
        chk("mrst max_outp", 32'(bus.max_outp), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick;
        chk("post_rst idle", 32'(bus.in_ready), 32'd0);
        begin
            vec_t v;
            v.name   = "after_rst";
            v.len    = 1;
            v.b      = '0;
            v.b[0]   = beat(16'h4200, 16'h0000, 16'h0000, 16'h0000);
            v.vpat   = 16'hFFFF;
            v.exp    = 16'h4200;
            v.xstart = 1'b0;
            run_vec(v);
        end

        chk("sb empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
